// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, T-state encodings
// and bit positions inside the internal control word.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // The encoding doubles as the TSTATE output value, so HALT must be 0.
    typedef enum logic [2:0] {
        T_HALT = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T5     = 3'd5,
        T6     = 3'd6
    } tstate_e;

    localparam int CW_PC_OUT   = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_RAM_WE   = 5;
    localparam int CW_IR_LOAD  = 6;
    localparam int CW_IR_OUT   = 7;
    localparam int CW_A_LOAD   = 8;
    localparam int CW_A_OUT    = 9;
    localparam int CW_B_LOAD   = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_OUT_LOAD = 13;
    localparam int CW_W        = 14;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bus-side signals of the control sequencer: enable and opcode in, one-hot
// register controls and status out.
interface ctrl_sequencer_if #(
    parameter int OPCODE_W = 4
);
    logic                ENABLE;
    logic [OPCODE_W-1:0] OPCODE;
    logic                PC_OUT;
    logic                PC_INC;
    logic                PC_LOAD;
    logic                MAR_LOAD;
    logic                RAM_OUT;
    logic                RAM_WE;
    logic                IR_LOAD;
    logic                IR_OUT;
    logic                A_LOAD;
    logic                A_OUT;
    logic                B_LOAD;
    logic                ALU_OUT;
    logic                ALU_SUB;
    logic                OUT_LOAD;
    logic                HALTED;
    logic [2:0]          TSTATE;

    modport master (
        input  ENABLE, OPCODE,
        output PC_OUT, PC_INC, PC_LOAD, MAR_LOAD, RAM_OUT, RAM_WE, IR_LOAD,
               IR_OUT, A_LOAD, A_OUT, B_LOAD, ALU_OUT, ALU_SUB, OUT_LOAD,
               HALTED, TSTATE
    );

    modport slave (
        output ENABLE, OPCODE,
        input  PC_OUT, PC_INC, PC_LOAD, MAR_LOAD, RAM_OUT, RAM_WE, IR_LOAD,
               IR_OUT, A_LOAD, A_OUT, B_LOAD, ALU_OUT, ALU_SUB, OUT_LOAD,
               HALTED, TSTATE
    );
endinterface

// File: rtl/ctrl_sequencer_tstate_counter.sv
// T-state counter: advances T1..LAST_T when enabled, can jump back to T1 early,
// locks in HALT until reset.
module tstate_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int LAST_T = 6
) (
    input  logic    clk,
    input  logic    srst,
    input  logic    en,
    input  logic    clr,
    input  logic    halt,
    output tstate_e state
);

    tstate_e state_q;
    tstate_e state_d;

    always_comb begin
        state_d = state_q;
        if (en && state_q != T_HALT) begin
            if (halt) begin
                state_d = T_HALT;
            end else if (clr || state_q == tstate_e'(3'(LAST_T))) begin
                state_d = T1;
            end else begin
                state_d = tstate_e'(3'(state_q) + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer: fixed three-cycle fetch followed by a per-opcode execute
// phase, decoding (T-state, opcode) into a one-hot register control word.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6
) (
    input  logic               clk,
    input  logic               REST,
    ctrl_sequencer_if.master   bus
);

    logic                live;
    logic [OPCODE_W-1:0] opcode;
    tstate_e             tstate;
    logic                early_clr;
    logic                halt_req;
    ctrl_word_t          ctrl_word;
    logic [4:0]          bus_drivers;

    assign live   = bus.ENABLE & ~REST;
    assign opcode = bus.OPCODE;

    tstate_counter #(
        .LAST_T (NUM_T)
    ) u_tstate (
        .clk   (clk),
        .srst  (REST),
        .en    (live),
        .clr   (early_clr),
        .halt  (halt_req),
        .state (tstate)
    );

    // Short instructions leave from T4; only the counter looks at these.
    always_comb begin
        early_clr = 1'b0;
        halt_req  = 1'b0;
        if (tstate == T4) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: early_clr = 1'b0;
                OP_HLT:                         halt_req  = 1'b1;
                default:                        early_clr = 1'b1;
            endcase
        end
    end

    always_comb begin
        ctrl_word = '0;
        if (live) begin
            case (tstate)
                T1: begin
                    ctrl_word[CW_PC_OUT]   = 1'b1;
                    ctrl_word[CW_MAR_LOAD] = 1'b1;
                end
                T2: ctrl_word[CW_PC_INC] = 1'b1;
                T3: begin
                    ctrl_word[CW_RAM_OUT] = 1'b1;
                    ctrl_word[CW_IR_LOAD] = 1'b1;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_word[CW_IR_OUT]   = 1'b1;
                            ctrl_word[CW_MAR_LOAD] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_word[CW_IR_OUT]  = 1'b1;
                            ctrl_word[CW_PC_LOAD] = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl_word[CW_A_OUT]    = 1'b1;
                            ctrl_word[CW_OUT_LOAD] = 1'b1;
                        end
                        default: ctrl_word = '0;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl_word[CW_RAM_OUT] = 1'b1;
                            ctrl_word[CW_A_LOAD]  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_word[CW_RAM_OUT] = 1'b1;
                            ctrl_word[CW_B_LOAD]  = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_word[CW_A_OUT]  = 1'b1;
                            ctrl_word[CW_RAM_WE] = 1'b1;
                        end
                        default: ctrl_word = '0;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin
                            ctrl_word[CW_ALU_OUT] = 1'b1;
                            ctrl_word[CW_A_LOAD]  = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl_word[CW_ALU_OUT] = 1'b1;
                            ctrl_word[CW_A_LOAD]  = 1'b1;
                            ctrl_word[CW_ALU_SUB] = 1'b1;
                        end
                        default: ctrl_word = '0;
                    endcase
                end
                default: ctrl_word = '0;
            endcase
        end
    end

    assign bus.PC_OUT   = ctrl_word[CW_PC_OUT];
    assign bus.PC_INC   = ctrl_word[CW_PC_INC];
    assign bus.PC_LOAD  = ctrl_word[CW_PC_LOAD];
    assign bus.MAR_LOAD = ctrl_word[CW_MAR_LOAD];
    assign bus.RAM_OUT  = ctrl_word[CW_RAM_OUT];
    assign bus.RAM_WE   = ctrl_word[CW_RAM_WE];
    assign bus.IR_LOAD  = ctrl_word[CW_IR_LOAD];
    assign bus.IR_OUT   = ctrl_word[CW_IR_OUT];
    assign bus.A_LOAD   = ctrl_word[CW_A_LOAD];
    assign bus.A_OUT    = ctrl_word[CW_A_OUT];
    assign bus.B_LOAD   = ctrl_word[CW_B_LOAD];
    assign bus.ALU_OUT  = ctrl_word[CW_ALU_OUT];
    assign bus.ALU_SUB  = ctrl_word[CW_ALU_SUB];
    assign bus.OUT_LOAD = ctrl_word[CW_OUT_LOAD];
    assign bus.HALTED   = (tstate == T_HALT);
    assign bus.TSTATE   = 3'(tstate);

    // Shared bus: at most one driver, and the PC never counts and jumps at once.
    assign bus_drivers = {ctrl_word[CW_PC_OUT], ctrl_word[CW_RAM_OUT],
                          ctrl_word[CW_IR_OUT], ctrl_word[CW_A_OUT],
                          ctrl_word[CW_ALU_OUT]};

    a_single_bus_driver: assert property (@(posedge clk) $onehot0(bus_drivers));
    a_pc_inc_xor_load:   assert property (@(posedge clk)
                             !(ctrl_word[CW_PC_INC] && ctrl_word[CW_PC_LOAD]));

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control sequencer for the von Neumann CPU; the consumer side of the instruction register.
- Drives LOAD into the IR, takes the IR's 4-bit DATA_OUT back as OPCODE, and steps a T-state machine.
- Emits the one-hot control word for the PC, MAR, RAM, IR, A, B, ALU and OUT registers sharing the bus.
- Handles fetch (T1–T3) and per-opcode execute (T4–T6), with early return to fetch and HALT.

Parameters:
OPCODE_W, 4, width of opcode from IR DATA_OUT
NUM_T, 6, T-states per instruction (fetch is fixed at 3)

Ports:
clk  input  1  system clock, all state changes on rising edge
REST  input  1  synchronous active-high reset
ENABLE  input  1  1 = advance one T-state per clk; 0 = freeze state, all controls 0
OPCODE  input  OPCODE_W  opcode from IR DATA_OUT
PC_OUT  output  1  PC drives bus
PC_INC  output  1  PC increments
PC_LOAD  output  1  PC loads from bus (jump)
MAR_LOAD  output  1  MAR loads from bus
RAM_OUT  output  1  RAM drives bus
RAM_WE  output  1  RAM writes bus at MAR
IR_LOAD  output  1  LOAD strobe to IR
IR_OUT  output  1  IR operand field drives bus
A_LOAD  output  1  accumulator loads
A_OUT  output  1  accumulator drives bus
B_LOAD  output  1  B register loads
ALU_OUT  output  1  ALU result drives bus
ALU_SUB  output  1  ALU subtract select
OUT_LOAD  output  1  output register loads
HALTED  output  1  sequencer in HALT
TSTATE  output  3  current T-state (1..6; 0 in HALT)

Behaviour:
- Sync reset: REST sampled high at a clk edge puts the state in T1, so TSTATE=1 and HALTED=0.
- While REST is high, every control output is 0.
- Reset mid-instruction or in HALT aborts immediately. The first cycle after REST falls is T1 fetch.
- Controls are combinational decodes of (state, OPCODE), gated by ENABLE & ~REST.
- Each control is valid for exactly one T-state, and the target register captures at the closing clk edge.
- ENABLE=0 holds the state and forces all controls to 0. This prevents repeated PC_INC or IR_LOAD.
- Fetch, identical for every instruction:
  - T1: PC_OUT, MAR_LOAD.
  - T2: PC_INC.
  - T3: RAM_OUT, IR_LOAD.
- OPCODE is the IR output registered at the end of T3. It is used only in T4–T6. Its value in T1–T3 is don't-care and must not affect any output.
- Execute, per OPCODE:
  - 0000 LDA: T4 IR_OUT+MAR_LOAD; T5 RAM_OUT+A_LOAD; T6 none.
  - 0001 ADD: T4 IR_OUT+MAR_LOAD; T5 RAM_OUT+B_LOAD; T6 ALU_OUT+A_LOAD.
  - 0010 SUB: same as ADD, with ALU_SUB=1 in T6.
  - 0011 STA: T4 IR_OUT+MAR_LOAD; T5 A_OUT+RAM_WE; T6 none.
  - 0100 JMP: T4 IR_OUT+PC_LOAD. Then return to T1 (early exit).
  - 1110 OUT: T4 A_OUT+OUT_LOAD. Then return to T1.
  - 1111 HLT: at the end of T4, enter HALT. In HALT, HALTED=1, TSTATE=0 and all controls are 0. Only REST exits.
  - Any other opcode is a NOP. T4 has no controls, then return to T1.
- Transitions:
  - T1→T2→T3→T4.
  - From T4: JMP, OUT and NOP go to T1; HLT goes to HALT; the rest go to T5.
  - T5→T6→T1 (wrap-around).
- Exactly one bus driver at most in any state: PC_OUT, RAM_OUT, IR_OUT, A_OUT or ALU_OUT. An assertion must check this.
- PC_INC and PC_LOAD are never asserted together.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_OUT, OP_HLT;
  - T-state encodings T1..T6 and T_HALT;
  - control-word bit indices.
- One sub-module, tstate_counter: a 3-bit counter with hold (ENABLE), early-clear (back to T1), halt-lock and sync REST.
- Opcode decode stays in ctrl_sequencer.

Test Plan:
- REST=1 for 2 cycles with ENABLE=1 → all controls 0 and TSTATE=1. After release, cycles 1–3 show {PC_OUT,MAR_LOAD}, {PC_INC}, {RAM_OUT,IR_LOAD}.
- OPCODE=0001 presented at T4 → T4 IR_OUT+MAR_LOAD, T5 RAM_OUT+B_LOAD, T6 ALU_OUT+A_LOAD with ALU_SUB=0, next cycle TSTATE=1. Repeat with 0010 → ALU_SUB=1 in T6 only.
- OPCODE=0100 → T4 IR_OUT+PC_LOAD, next cycle TSTATE=1, 4-cycle instruction. Repeat with 1110 → A_OUT+OUT_LOAD, same 4-cycle length.
- OPCODE=1111 → after T4, HALTED=1, TSTATE=0 and no controls for 20 cycles. Pulse REST for 1 cycle → TSTATE=1, HALTED=0.
- ENABLE=0 for 5 cycles during T2 → TSTATE stays 2 and PC_INC stays 0 throughout. On re-enable, PC_INC is high for exactly 1 cycle.
- REST pulsed during T5 of ADD → B_LOAD and A_LOAD never fire, and the next cycle is T1. Undefined OPCODE=1010 → NOP with 4-cycle length and no controls in T4.
